// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Watches the game state machine's 2-bit state and keeps a BCD score while
//   the game is PLAYING: one point per survival tick (every TICK_DIV clocks)
//   and one point per obstacle_passed pulse. When PLAYING ends in GAME_OVER
//   the score is compared with the best score since reset, and the best score
//   is replaced if the new one is strictly greater. Digits drive the HEX
//   display decoders directly.
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous, active-high reset
//   state           in   game state: 00 START, 01 PLAYING, 10 INSTRUCTIONS,
//                        11 GAME_OVER
//   obstacle_passed in   1-cycle pulse, counted only while in a running game
//   score_bcd       out  current or last score, BCD, digit 0 in bits [3:0]
//   high_bcd        out  best score since reset, BCD
//   new_high        out  last game beat the previous high score
//   saturated       out  score clamped at all-9s during the current/last game
// -----------------------------------------------------------------------------
module score_keeper #(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIGITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            state,
   input  logic                  obstacle_passed,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   high_bcd,
   output logic                  new_high,
   output logic                  saturated
);

   localparam int                  CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [1:0]          ST_PLAYING   = 2'b01;
   localparam logic [1:0]          ST_GAME_OVER = 2'b11;
   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      FSM_IDLE = 2'b00,
      FSM_RUN  = 2'b01,
      FSM_HOLD = 2'b10
   } fsm_t;

   // BCD add of a small increment (0..2) with per-digit carry ripple.
   // Returns {carry_out, sum}; a carry out of the top digit means overflow.
   function automatic logic [4*DIGITS:0] bcd_add(input logic [4*DIGITS-1:0] a,
                                                 input logic [1:0]          inc);
      logic [4*DIGITS-1:0] sum;
      logic [4:0]          d;
      logic                c;
      sum = '0;
      d   = {1'b0, a[3:0]} + {3'b000, inc};
      c   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i != 0) begin
            d = {1'b0, a[4*i +: 4]} + {4'b0000, c};
         end
         if (d > 5'd9) begin
            sum[4*i +: 4] = 4'(d - 5'd10);
            c             = 1'b1;
         end else begin
            sum[4*i +: 4] = d[3:0];
            c             = 1'b0;
         end
      end
      return {c, sum};
   endfunction

   // Strictly-greater compare, decided by the most significant differing digit.
   function automatic logic bcd_gt(input logic [4*DIGITS-1:0] a,
                                   input logic [4*DIGITS-1:0] b);
      logic gt;
      logic decided;
      gt      = 1'b0;
      decided = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
            gt      = (a[4*i +: 4] > b[4*i +: 4]);
            decided = 1'b1;
         end
      end
      return gt;
   endfunction

   fsm_t                r_fsm;
   fsm_t                w_fsm_next;
   logic [1:0]          r_prev_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [4*DIGITS-1:0] r_score;
   logic [4*DIGITS-1:0] r_high;
   logic                r_new_high;
   logic                r_sat;

   logic                w_start_evt;
   logic                w_end_evt;
   logic                w_tick;
   logic [1:0]          w_inc;
   logic [4*DIGITS:0]   w_sum;
   logic                w_ovf;
   logic [4*DIGITS-1:0] w_next_score;

   assign w_start_evt  = (state == ST_PLAYING) && (r_prev_state != ST_PLAYING);
   assign w_end_evt    = (state != ST_PLAYING) && (r_prev_state == ST_PLAYING);
   assign w_tick       = (r_cnt == TICK_LAST);
   assign w_inc        = {1'b0, w_tick} + {1'b0, obstacle_passed};
   assign w_sum        = bcd_add(r_score, w_inc);
   assign w_ovf        = w_sum[4*DIGITS];
   // Clamp instead of wrapping to zero.
   assign w_next_score = w_ovf ? ALL_NINES : w_sum[4*DIGITS-1:0];

   // Control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm        <= FSM_IDLE;
         r_prev_state <= 2'b00;
      end else begin
         r_fsm        <= w_fsm_next;
         r_prev_state <= state;
      end
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         FSM_IDLE: if (w_start_evt) w_fsm_next = FSM_RUN;
         FSM_RUN:  if (w_end_evt)   w_fsm_next = FSM_HOLD;
         FSM_HOLD: if (w_start_evt) w_fsm_next = FSM_RUN;
         default:  w_fsm_next = FSM_IDLE;
      endcase
   end

   // Score, tick counter and high score
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_score    <= '0;
         r_high     <= '0;
         r_new_high <= 1'b0;
         r_sat      <= 1'b0;
      end else if (w_start_evt) begin
         // A pass pulse on the start edge is dropped on purpose.
         r_cnt      <= '0;
         r_score    <= '0;
         r_new_high <= 1'b0;
         r_sat      <= 1'b0;
      end else if (r_fsm == FSM_RUN) begin
         if (w_end_evt) begin
            // Events on the end edge are discarded; the registered score is final.
            if ((state == ST_GAME_OVER) && bcd_gt(r_score, r_high)) begin
               r_high     <= r_score;
               r_new_high <= 1'b1;
            end
         end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_inc != 2'd0) begin
               r_score <= w_next_score;
               if (w_ovf) begin
                  r_sat <= 1'b1;
               end
            end
         end
      end
   end

   assign score_bcd = r_score;
   assign high_bcd  = r_high;
   assign new_high  = r_new_high;
   assign saturated = r_sat;

endmodule
